// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the decode stage and the multi-cycle multiply/divide unit.
// Handshake: start is honoured only on an edge where busy is low and flush is low; done pulses for one cycle when hi/lo change.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, opA, opB, flush,
        input  busy, done, div_by_zero, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, opA, opB, flush,
        output busy, done, div_by_zero, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide on magnitudes,
// sign fix-up in a final cycle, results held in architectural HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;       // upper product half or partial remainder
    logic [WIDTH-1:0] shr_q, shr_d;       // multiplier or dividend/quotient shift register
    logic [WIDTH-1:0] orig_a_q, orig_a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    always_comb begin
        a_neg   = bus.op[0] & bus.opA[WIDTH-1];
        b_neg   = bus.op[0] & bus.opB[WIDTH-1];
        a_mag   = a_neg ? -bus.opA : bus.opA;
        b_mag   = b_neg ? -bus.opB : bus.opB;
        mul_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_q, shr_q[WIDTH-1]};
        prod    = {acc_q, shr_q};
        quo     = shr_q;
        rem     = acc_q;

        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        shr_d    = shr_q;
        orig_a_d = orig_a_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (!bus.flush && bus.start) begin
                    op_d     = bus.op;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    mcand_d  = bus.op[1] ? b_mag : a_mag;
                    shr_d    = bus.op[1] ? a_mag : b_mag;
                    orig_a_d = bus.opA;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (!op_q[1]) begin
                        acc_d = mul_sum[WIDTH:1];
                        shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
                    end else if (rem_sh >= {1'b0, mcand_q}) begin
                        acc_d = WIDTH'(rem_sh - {1'b0, mcand_q});
                        shr_d = {shr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = WIDTH'(rem_sh);
                        shr_d = {shr_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        if (sign_a_q ^ sign_b_q) prod = -prod;
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (mcand_q == '0) begin
                        // Divisor magnitude is zero only when opB itself was zero
                        dbz_d = 1'b1;
                        hi_d  = orig_a_q;
                        lo_d  = '1;
                    end else begin
                        if (sign_a_q ^ sign_b_q) quo = -quo;
                        if (sign_a_q) rem = -rem;
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            shr_q    <= '0;
            orig_a_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            orig_a_q <= orig_a_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.dbg_state   = state_q;
endmodule
